// File: rtl/lsu_pkg.sv
// Shared types, address map and lane helpers for the lsu_hs load-store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RESP
   } state_e;

   localparam logic [11:0] ADDR_HEX_BASE = 12'h800;
   localparam logic [11:0] HEX_STRIDE    = 12'h010;
   localparam logic [11:0] ADDR_LEDR     = 12'h880;
   localparam logic [11:0] ADDR_LEDG     = 12'h890;
   localparam logic [11:0] ADDR_LCD      = 12'h8A0;
   localparam logic [11:0] ADDR_SW       = 12'h900;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   // Shift the selected lane down to bit 0, then zero- or sign-extend.
   function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         SZ_BYTE: return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module lsu_dmem #(
   parameter int DMEM_DEPTH = 2048,
   parameter int AW         = (DMEM_DEPTH > 4) ? $clog2(DMEM_DEPTH / 4) : 1
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   localparam int WORDS = DMEM_DEPTH / 4;

   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_hs.sv
// Single-outstanding load-store unit: stores/errors respond 1 cycle after accept, loads 2; holds response until rsp_ready_i.
// LSU_MISALIGN_TRAP_EN: misaligned half/word become errors instead of being silently aligned.
module lsu_hs
   import lsu_pkg::*;
#(
   parameter int DMEM_DEPTH     = 2048,
   parameter int N_HEX          = 8,
   parameter int SW_SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [31:0]         req_addr_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_unsigned_i,
   input  logic [31:0]         req_wdata_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [31:0]         rsp_rdata_o,
   output logic                rsp_err_o,
   input  logic [31:0]         io_sw_i,
   output logic [32*N_HEX-1:0] io_hex_o,
   output logic [31:0]         io_ledr_o,
   output logic [31:0]         io_ledg_o,
   output logic [31:0]         io_lcd_o
);

   localparam int          AW        = (DMEM_DEPTH > 4) ? $clog2(DMEM_DEPTH / 4) : 1;
   localparam logic [12:0] DEPTH_LIM = 13'(DMEM_DEPTH);

   state_e state_q, state_d;

   logic [11:0] a;
   logic [1:0]  lane;
   logic        is_mem, is_sw, is_ledr, is_ledg, is_lcd, hex_hit, err, accept, commit;
   logic [2:0]  hex_idx;
   logic [3:0]  be;
   logic [31:0] wd_rep, wmask, prd, hex_rd, ram_rdata;

   logic [32*N_HEX-1:0]                 hex_q;
   logic [31:0]                         ledr_q, ledg_q, lcd_q, prd_q, rsp_rdata_q;
   logic [SW_SYNC_STAGES-1:0][31:0]     sw_q;
   logic [1:0]                          lane_q, size_q;
   logic                                uns_q, mem_sel_q, rsp_err_q;
   logic [19:0]                         addr_unused;

   assign addr_unused = req_addr_i[31:12];

   always_comb begin
      a       = req_addr_i[11:0];
      lane    = a[1:0];
      hex_hit = 1'b0;
      hex_idx = 3'd0;
      hex_rd  = 32'd0;
      for (int k = 0; k < N_HEX; k++) begin
         logic [11:0] hb;
         hb = ADDR_HEX_BASE + HEX_STRIDE * 12'(k);
         if (a[11:2] == hb[11:2]) begin
            hex_hit = 1'b1;
            hex_idx = 3'(k);
            hex_rd  = hex_q[32*k +: 32];
         end
      end
      is_mem  = {1'b0, a} < DEPTH_LIM;
      is_ledr = a[11:2] == ADDR_LEDR[11:2];
      is_ledg = a[11:2] == ADDR_LEDG[11:2];
      is_lcd  = a[11:2] == ADDR_LCD[11:2];
      is_sw   = a[11:2] == ADDR_SW[11:2];
      err = (req_size_i == 2'b11) || (req_we_i && is_sw) ||
            !(is_mem || hex_hit || is_ledr || is_ledg || is_lcd || is_sw);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((req_size_i == SZ_HALF && a[0]) || (req_size_i == SZ_WORD && a[1:0] != 2'b00))
         err = 1'b1;
`else
      if (req_size_i == SZ_HALF) lane[0] = 1'b0;
      if (req_size_i == SZ_WORD) lane    = 2'b00;
`endif
      case (req_size_i)
         SZ_BYTE: begin be = 4'b0001 << lane; wd_rep = {4{req_wdata_i[7:0]}};  end
         SZ_HALF: begin be = 4'b0011 << lane; wd_rep = {2{req_wdata_i[15:0]}}; end
         default: begin be = 4'b1111;         wd_rep = req_wdata_i;            end
      endcase
      wmask = be_to_mask(be);
      prd   = hex_rd;
      if (is_ledr) prd = ledr_q;
      if (is_ledg) prd = ledg_q;
      if (is_lcd)  prd = lcd_q;
      if (is_sw)   prd = sw_q[SW_SYNC_STAGES-1];
   end

   assign accept = req_valid_i & req_ready_o;
   assign commit = accept & req_we_i & ~err;

   lsu_dmem #(.DMEM_DEPTH(DMEM_DEPTH), .AW(AW)) u_dmem (
      .clk_i   (clk_i),
      .we_i    (commit & is_mem),
      .be_i    (be),
      .addr_i  (a[AW+1:2]),
      .wdata_i (wd_rep),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Handshake outputs are gated by rst_i so an abandoned response never completes.
   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = ~rst_i;
            if (req_valid_i && !rst_i) state_d = (err || req_we_i) ? RESP : LOAD;
         end
         LOAD: state_d = RESP;
         RESP: begin
            rsp_valid_o = ~rst_i;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hex_q       <= '0;
         ledr_q      <= '0;
         ledg_q      <= '0;
         lcd_q       <= '0;
         sw_q        <= '0;
         prd_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         lane_q      <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         mem_sel_q   <= 1'b0;
      end else begin
         sw_q[0] <= io_sw_i;
         for (int i = 1; i < SW_SYNC_STAGES; i++) sw_q[i] <= sw_q[i-1];
         if (accept) begin
            lane_q      <= lane;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            mem_sel_q   <= is_mem;
            prd_q       <= prd;
            rsp_err_q   <= err;
            rsp_rdata_q <= '0;
         end
         if (commit) begin
            for (int k = 0; k < N_HEX; k++) begin
               if (hex_hit && hex_idx == 3'(k))
                  hex_q[32*k +: 32] <= (hex_q[32*k +: 32] & ~wmask) | (wd_rep & wmask);
            end
            if (is_ledr) ledr_q <= (ledr_q & ~wmask) | (wd_rep & wmask);
            if (is_ledg) ledg_q <= (ledg_q & ~wmask) | (wd_rep & wmask);
            if (is_lcd)  lcd_q  <= (lcd_q  & ~wmask) | (wd_rep & wmask);
         end
         if (state_q == LOAD)
            rsp_rdata_q <= load_fmt(mem_sel_q ? ram_rdata : prd_q, lane_q, size_q, uns_q);
      end
   end

   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign io_hex_o    = hex_q;
   assign io_ledr_o   = ledr_q;
   assign io_ledg_o   = ledg_q;
   assign io_lcd_o    = lcd_q;

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs built with DMEM_DEPTH=1024, N_HEX=4; expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_hs;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_we, req_uns;
   logic [31:0]  req_addr, req_wdata;
   logic [1:0]   req_size;
   logic         rsp_valid, rsp_ready, rsp_err;
   logic [31:0]  rsp_rdata, io_sw, io_ledr, io_ledg, io_lcd;
   logic [127:0] io_hex;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_hs #(.DMEM_DEPTH(1024), .N_HEX(4), .SW_SYNC_STAGES(2)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_addr_i     (req_addr),
      .req_size_i     (req_size),
      .req_unsigned_i (req_uns),
      .req_wdata_i    (req_wdata),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_rdata_o    (rsp_rdata),
      .rsp_err_o      (rsp_err),
      .io_sw_i        (io_sw),
      .io_hex_o       (io_hex),
      .io_ledr_o      (io_ledr),
      .io_ledg_o      (io_ledg),
      .io_lcd_o       (io_lcd)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a request and returns at the negedge just after the accept edge.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input logic early);
      int n;
      @(negedge clk);
      req_we = we; req_addr = addr; req_size = sz; req_uns = uns; req_wdata = wd;
      req_valid = 1'b1; rsp_ready = early;
      #1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
      chk_eq("req_rdy", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      #1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); #1; lat++; end
      chk_eq("rsp_vld", 32'(rsp_valid), 32'd1);
   endtask

   task automatic finish_rsp;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk_eq("no_dup", 32'(rsp_valid), 32'd0);
   endtask

   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input logic early);
      int lat;
      issue(we, addr, sz, uns, wd, early);
      wait_rsp(lat);
      chk_eq({tag, "_rd"}, rsp_rdata, exp_rd);
      chk_eq({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      chk_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      finish_rsp();
   endtask

   initial begin
      int lat;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b00;
      req_uns = 1'b0; req_wdata = '0; rsp_ready = 1'b0; io_sw = 32'h5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_ready", 32'(req_ready), 32'd0);
      chk_eq("rst_valid", 32'(rsp_valid), 32'd0);
      chk_eq("rst_rdata", rsp_rdata, 32'd0);
      chk_eq("rst_err", 32'(rsp_err), 32'd0);
      chk_eq("rst_hex0", io_hex[31:0], 32'd0);
      chk_eq("rst_hex3", io_hex[127:96], 32'd0);
      chk_eq("rst_ledr", io_ledr, 32'd0);
      chk_eq("rst_ledg", io_ledg, 32'd0);
      chk_eq("rst_lcd", io_lcd, 32'd0);
      rst = 1'b0;
      @(negedge clk); #1;
      chk_eq("rel_ready", 32'(req_ready), 32'd1);
      chk_eq("rel_valid", 32'(rsp_valid), 32'd0);

      txn("sw_load", 0, 32'h900, 2'b10, 0, 0, 32'h5, 0, 2, 0);

      txn("st_w010", 1, 32'h010, 2'b10, 0, 32'h8000_00FF, 32'h0, 0, 1, 0);
      txn("lb_010",  0, 32'h010, 2'b00, 0, 0, 32'hFFFF_FFFF, 0, 2, 0);
      txn("lbu_013", 0, 32'h013, 2'b00, 1, 0, 32'h0000_0080, 0, 2, 0);
      txn("lh_012",  0, 32'h012, 2'b01, 0, 0, 32'hFFFF_8000, 0, 2, 0);
      txn("lhu_010", 0, 32'h010, 2'b01, 1, 0, 32'h0000_00FF, 0, 2, 0);
      txn("lw_010",  0, 32'h010, 2'b10, 0, 0, 32'h8000_00FF, 0, 2, 0);

      issue(1, 32'h821, 2'b00, 0, 32'h0000_00AB, 0);
      #1;
      chk_eq("hex2_t1", io_hex[95:64], 32'h0000_AB00);
      wait_rsp(lat);
      chk_eq("hex2_lat", 32'(lat), 32'd1);
      finish_rsp();
      chk_eq("hex1_clean", io_hex[63:32], 32'd0);
      txn("lw_820", 0, 32'h820, 2'b10, 0, 0, 32'h0000_AB00, 0, 2, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      txn("lw_012", 0, 32'h012, 2'b10, 0, 0, 32'h0, 1, 1, 0);
      txn("lh_013", 0, 32'h013, 2'b01, 0, 0, 32'h0, 1, 1, 0);
      txn("sh_011", 1, 32'h011, 2'b01, 0, 32'h0000_1234, 32'h0, 1, 1, 0);
      txn("lw_chk", 0, 32'h010, 2'b10, 0, 0, 32'h8000_00FF, 0, 2, 0);
`else
      txn("lw_012", 0, 32'h012, 2'b10, 0, 0, 32'h8000_00FF, 0, 2, 0);
      txn("lh_013", 0, 32'h013, 2'b01, 0, 0, 32'hFFFF_8000, 0, 2, 0);
      txn("sh_011", 1, 32'h011, 2'b01, 0, 32'h0000_1234, 32'h0, 0, 1, 0);
      txn("lw_chk", 0, 32'h010, 2'b10, 0, 0, 32'h8000_1234, 0, 2, 0);
`endif
      txn("st_sw",   1, 32'h900, 2'b10, 0, 32'hFFFF_FFFF, 32'h0, 1, 1, 0);
      txn("sw_again", 0, 32'h900, 2'b10, 0, 0, 32'h5, 0, 2, 0);

      txn("hex4_unm", 0, 32'h840, 2'b10, 0, 0, 32'h0, 1, 1, 0);
      txn("st_hex3",  1, 32'h830, 2'b10, 0, 32'hDEAD_BEEF, 32'h0, 0, 1, 0);
      chk_eq("hex3_val", io_hex[127:96], 32'hDEAD_BEEF);
      txn("mem_top_w", 1, 32'h3FC, 2'b10, 0, 32'h5A5A_1234, 32'h0, 0, 1, 0);
      txn("mem_top_r", 0, 32'h3FC, 2'b10, 0, 0, 32'h5A5A_1234, 0, 2, 0);
      txn("mem_unm",   0, 32'h400, 2'b10, 0, 0, 32'h0, 1, 1, 0);
      txn("rsv_size",  0, 32'h010, 2'b11, 0, 0, 32'h0, 1, 1, 0);
      txn("ledr_off4", 0, 32'h884, 2'b10, 0, 0, 32'h0, 1, 1, 0);

      txn("st_ledr", 1, 32'h882, 2'b01, 0, 32'h0000_1234, 32'h0, 0, 1, 0);
      chk_eq("ledr_val", io_ledr, 32'h1234_0000);
      txn("st_ledg", 1, 32'h893, 2'b00, 0, 32'h0000_007E, 32'h0, 0, 1, 0);
      chk_eq("ledg_val", io_ledg, 32'h7E00_0000);
      txn("lb_ledg", 0, 32'h893, 2'b00, 0, 0, 32'h0000_007E, 0, 2, 0);
      txn("st_lcd",  1, 32'h8A0, 2'b10, 0, 32'hA5A5_A5A5, 32'h0, 0, 1, 0);
      chk_eq("lcd_val", io_lcd, 32'hA5A5_A5A5);
      txn("lbu_lcd", 0, 32'h8A1, 2'b00, 1, 0, 32'h0000_00A5, 0, 2, 0);
      txn("lb_lcd",  0, 32'h8A1, 2'b00, 0, 0, 32'hFFFF_FFA5, 0, 2, 0);

      txn("early_rdy", 0, 32'h3FC, 2'b10, 0, 0, 32'h5A5A_1234, 0, 2, 1);

      issue(0, 32'h3FC, 2'b10, 0, 0, 0);
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk_eq("hold_vld", 32'(rsp_valid), 32'd1);
         chk_eq("hold_rd", rsp_rdata, 32'h5A5A_1234);
         chk_eq("hold_rdy", 32'(req_ready), 32'd0);
      end
      finish_rsp();

      issue(1, 32'h020, 2'b10, 0, 32'h1122_3344, 0);
      wait_rsp(lat);
      @(negedge clk);
      rst = 1'b1; rsp_ready = 1'b1;
      #1;
      chk_eq("rst_mid_vld", 32'(rsp_valid), 32'd0);
      chk_eq("rst_mid_rdy", 32'(req_ready), 32'd0);
      @(negedge clk); #1;
      chk_eq("rst_mid_ledr", io_ledr, 32'd0);
      chk_eq("rst_mid_hex3", io_hex[127:96], 32'd0);
      rst = 1'b0; rsp_ready = 1'b0;
      @(negedge clk); #1;
      chk_eq("post_rst_vld", 32'(rsp_valid), 32'd0);
      chk_eq("post_rst_rdy", 32'(req_ready), 32'd1);
      txn("persist", 0, 32'h020, 2'b10, 0, 0, 32'h1122_3344, 0, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
